// File: rtl/rx_pkg.sv
// rtl/rx_pkg.sv - XGMII character constants and receive FSM encoding shared across rx_engine
package rx_pkg;

  localparam logic [7:0] XGMII_START = 8'hFB;
  localparam logic [7:0] XGMII_TERM  = 8'hFD;
  localparam logic [7:0] XGMII_ERR   = 8'hFE;
  localparam logic [7:0] XGMII_PRE   = 8'h55;
  localparam logic [7:0] XGMII_SFD   = 8'hD5;
  localparam logic [7:0] XGMII_IDLE  = 8'h07;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DA      = 3'd1,
    ST_SA_LT   = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_DROP    = 3'd4
  } rx_state_e;

  // Byte of a 64-bit XGMII word by lane number; lane 0 is the first byte on the wire.
  function automatic logic [7:0] lane_byte(input logic [63:0] word, input int lane);
    return word[lane*8 +: 8];
  endfunction

endpackage

// File: rtl/rx_ctrl_decode.sv
// rtl/rx_ctrl_decode.sv - combinational classification of one XGMII receive word
module rx_ctrl_decode
  import rx_pkg::*;
(
  input  logic [63:0] rxd64,
  input  logic [7:0]  rxc64,
  output logic        is_start,
  output logic        is_pre_ok,
  output logic        has_term,
  output logic        has_err,
  output logic        has_ctrl
);

  // Start/preamble test on the fixed lane-0 alignment, plus a scan of every control lane
  always_comb begin
    is_start  = (rxc64 == 8'h01) && (lane_byte(rxd64, 0) == XGMII_START);
    is_pre_ok = (lane_byte(rxd64, 7) == XGMII_SFD);
    has_term  = 1'b0;
    has_err   = 1'b0;
    for (int i = 1; i < 7; i++) begin
      if (lane_byte(rxd64, i) != XGMII_PRE) begin
        is_pre_ok = 1'b0;
      end
    end
    for (int i = 0; i < 8; i++) begin
      if (rxc64[i] && (lane_byte(rxd64, i) == XGMII_TERM)) begin
        has_term = 1'b1;
      end
      if (rxc64[i] && (lane_byte(rxd64, i) == XGMII_ERR)) begin
        has_err = 1'b1;
      end
    end
  end

  assign has_ctrl = |rxc64;

endmodule

// File: rtl/rx_hdr_extractor.sv
// rtl/rx_hdr_extractor.sv - XGMII receive header parser: preamble check, DA/SA/Length-Type capture
module rx_hdr_extractor
  import rx_pkg::*;
#(
  parameter bit PREAMBLE_CHECK = 1'b1,
  parameter int TP             = 1
) (
  input  logic        rxclk,
  input  logic        reset,
  input  logic [63:0] rxd64,
  input  logic [7:0]  rxc64,
  output logic [47:0] da_addr,
  output logic [47:0] sa_addr,
  output logic [15:0] len_type,
  output logic        da_valid,
  output logic        hdr_valid,
  output logic        in_frame,
  output logic        preamble_err,
  output logic        hdr_err
);

  logic w_is_start;
  logic w_pre_ok;
  logic w_has_term;
  logic w_has_err;
  logic w_has_ctrl;
  logic w_unused_tp;

  rx_state_e   r_state;
  logic [47:0] r_da_addr;
  logic [47:0] r_sa_addr;
  logic [15:0] r_len_type;
  logic [15:0] r_sa_hi;
  logic        r_da_valid;
  logic        r_hdr_valid;
  logic        r_in_frame;
  logic        r_pre_err;
  logic        r_hdr_err;

  // TP only ever delayed nonblocking updates in simulation; this zero-delay RTL keeps it for drop-in use.
  assign w_unused_tp = (TP != 0);

  rx_ctrl_decode u_decode (
    .rxd64     (rxd64),
    .rxc64     (rxc64),
    .is_start  (w_is_start),
    .is_pre_ok (w_pre_ok),
    .has_term  (w_has_term),
    .has_err   (w_has_err),
    .has_ctrl  (w_has_ctrl)
  );

  // Header FSM; captures and one-cycle status pulses are registered alongside the state.
  // SA bytes from the DA word are staged so sa_addr only changes together with hdr_valid.
  always_ff @(posedge rxclk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_da_addr   <= '0;
      r_sa_addr   <= '0;
      r_len_type  <= '0;
      r_sa_hi     <= '0;
      r_da_valid  <= 1'b0;
      r_hdr_valid <= 1'b0;
      r_in_frame  <= 1'b0;
      r_pre_err   <= 1'b0;
      r_hdr_err   <= 1'b0;
    end else begin
      r_da_valid  <= 1'b0;
      r_hdr_valid <= 1'b0;
      r_pre_err   <= 1'b0;
      r_hdr_err   <= 1'b0;
      if (w_is_start) begin
        // A Start always re-synchronises; only an unfinished header counts as an error.
        r_hdr_err  <= (r_state == ST_DA) || (r_state == ST_SA_LT);
        r_in_frame <= 1'b1;
        if (w_pre_ok || !PREAMBLE_CHECK) begin
          r_state <= ST_DA;
        end else begin
          r_state   <= ST_DROP;
          r_pre_err <= 1'b1;
        end
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_in_frame <= 1'b0;
          end
          ST_DA: begin
            if (w_has_ctrl) begin
              r_hdr_err <= 1'b1;
              if (w_has_term) begin
                r_state    <= ST_IDLE;
                r_in_frame <= 1'b0;
              end else begin
                r_state <= ST_DROP;
              end
            end else begin
              r_da_addr  <= {rxd64[7:0], rxd64[15:8], rxd64[23:16],
                             rxd64[31:24], rxd64[39:32], rxd64[47:40]};
              r_sa_hi    <= {rxd64[55:48], rxd64[63:56]};
              r_da_valid <= 1'b1;
              r_state    <= ST_SA_LT;
            end
          end
          ST_SA_LT: begin
            if (w_has_ctrl) begin
              r_hdr_err <= 1'b1;
              if (w_has_term) begin
                r_state    <= ST_IDLE;
                r_in_frame <= 1'b0;
              end else begin
                r_state <= ST_DROP;
              end
            end else begin
              r_sa_addr   <= {r_sa_hi, rxd64[7:0], rxd64[15:8], rxd64[23:16], rxd64[31:24]};
              r_len_type  <= {rxd64[39:32], rxd64[47:40]};
              r_hdr_valid <= 1'b1;
              r_state     <= ST_PAYLOAD;
            end
          end
          ST_PAYLOAD, ST_DROP: begin
            if (w_has_term || w_has_err) begin
              r_state    <= ST_IDLE;
              r_in_frame <= 1'b0;
            end
          end
          default: begin
            r_state    <= ST_IDLE;
            r_in_frame <= 1'b0;
          end
        endcase
      end
    end
  end

  assign da_addr      = r_da_addr;
  assign sa_addr      = r_sa_addr;
  assign len_type     = r_len_type;
  assign da_valid     = r_da_valid;
  assign hdr_valid    = r_hdr_valid;
  assign in_frame     = r_in_frame;
  assign preamble_err = r_pre_err;
  assign hdr_err      = r_hdr_err;

endmodule

// File: tb/tb_rx_hdr_extractor.sv
// tb/tb_rx_hdr_extractor.sv - self-checking bench for rx_hdr_extractor
module tb_rx_hdr_extractor;

  localparam logic [63:0] W_START = 64'hD5555555555555FB;
  localparam logic [63:0] W_BADPR = 64'hD5555555545555FB;
  localparam logic [63:0] W_SFD4  = 64'hD4555555555555FB;
  localparam logic [63:0] W_DA1   = 64'h11000100_00C28001;
  localparam logic [63:0] W_DA2   = 64'hBBAA6655_44332211;
  localparam logic [63:0] W_SALT  = 64'hBBAA0888_55443322;
  localparam logic [63:0] W_PAY   = 64'h01234567_89ABCDEF;
  localparam logic [63:0] W_TERM  = 64'h07070707_070707FD;
  localparam logic [63:0] W_IDLE  = 64'h07070707_07070707;
  localparam logic [63:0] W_SHORT = 64'h07070707_07FD8001;
  localparam logic [63:0] W_ERR   = 64'h00000000_000000FE;

  localparam int P_OUT  = 0;
  localparam int P_DA   = 1;
  localparam int P_SA   = 2;
  localparam int P_PAY  = 3;
  localparam int P_DROP = 4;

  logic        clk;
  logic        resetn;
  logic [63:0] d;
  logic [7:0]  c;

  logic [47:0] a_da_addr, a_sa_addr, b_da_addr, b_sa_addr;
  logic [15:0] a_len_type, b_len_type;
  logic        a_da_valid, a_hdr_valid, a_in_frame, a_preamble_err, a_hdr_err;
  logic        b_da_valid, b_hdr_valid, b_in_frame, b_preamble_err, b_hdr_err;

  int n_cmp = 0;
  int n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  rx_hdr_extractor #(.PREAMBLE_CHECK(1'b1)) u_dut (
    .rxclk(clk), .reset(resetn), .rxd64(d), .rxc64(c),
    .da_addr(a_da_addr), .sa_addr(a_sa_addr), .len_type(a_len_type),
    .da_valid(a_da_valid), .hdr_valid(a_hdr_valid), .in_frame(a_in_frame),
    .preamble_err(a_preamble_err), .hdr_err(a_hdr_err)
  );

  rx_hdr_extractor #(.PREAMBLE_CHECK(1'b0)) u_nochk (
    .rxclk(clk), .reset(resetn), .rxd64(d), .rxc64(c),
    .da_addr(b_da_addr), .sa_addr(b_sa_addr), .len_type(b_len_type),
    .da_valid(b_da_valid), .hdr_valid(b_hdr_valid), .in_frame(b_in_frame),
    .preamble_err(b_preamble_err), .hdr_err(b_hdr_err)
  );

  // Reference model: position within the frame header plus held captures.
  // ev = {da_valid, hdr_valid, preamble_err, hdr_err, in_frame}
  typedef struct {
    int          pos;
    logic [47:0] da;
    logic [47:0] sa;
    logic [15:0] lt;
    logic [15:0] sa_hi;
    logic [4:0]  ev;
  } mdl_t;

  mdl_t m0, m1;

  function automatic mdl_t m_init();
    mdl_t s;
    s.pos = P_OUT; s.da = '0; s.sa = '0; s.lt = '0; s.sa_hi = '0; s.ev = '0;
    return s;
  endfunction

  function automatic mdl_t model_step(mdl_t s, logic [63:0] wd, logic [7:0] wc, bit chk);
    logic [7:0] b [8];
    bit st, pre, term, err;
    for (int i = 0; i < 8; i++) b[i] = wd[8*i +: 8];
    st   = (wc == 8'h01) && (b[0] == 8'hFB);
    pre  = (b[7] == 8'hD5);
    term = 0;
    err  = 0;
    for (int i = 1; i < 7; i++) if (b[i] != 8'h55) pre = 0;
    for (int i = 0; i < 8; i++) begin
      if (wc[i] && b[i] == 8'hFD) term = 1;
      if (wc[i] && b[i] == 8'hFE) err = 1;
    end
    s.ev = '0;
    if (st) begin
      if (s.pos == P_DA || s.pos == P_SA) s.ev[1] = 1'b1;
      if (pre || !chk) s.pos = P_DA;
      else begin s.pos = P_DROP; s.ev[2] = 1'b1; end
    end else if ((s.pos == P_DA || s.pos == P_SA) && wc != 8'h00) begin
      s.ev[1] = 1'b1;
      s.pos = term ? P_OUT : P_DROP;
    end else if (s.pos == P_DA) begin
      s.da = {b[0], b[1], b[2], b[3], b[4], b[5]};
      s.sa_hi = {b[6], b[7]};
      s.ev[4] = 1'b1;
      s.pos = P_SA;
    end else if (s.pos == P_SA) begin
      s.sa = {s.sa_hi, b[0], b[1], b[2], b[3]};
      s.lt = {b[4], b[5]};
      s.ev[3] = 1'b1;
      s.pos = P_PAY;
    end else if ((s.pos == P_PAY || s.pos == P_DROP) && (term || err)) begin
      s.pos = P_OUT;
    end
    s.ev[0] = (s.pos != P_OUT);
    return s;
  endfunction

  function automatic logic [116:0] pack_a();
    return {a_da_valid, a_hdr_valid, a_preamble_err, a_hdr_err, a_in_frame,
            a_da_addr, a_sa_addr, a_len_type};
  endfunction

  function automatic logic [116:0] pack_b();
    return {b_da_valid, b_hdr_valid, b_preamble_err, b_hdr_err, b_in_frame,
            b_da_addr, b_sa_addr, b_len_type};
  endfunction

  function automatic logic [116:0] pack_m(mdl_t s);
    return {s.ev, s.da, s.sa, s.lt};
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Present one word, let it be clocked in, then sample one step after the edge.
  task automatic drive(input logic [63:0] wd, input logic [7:0] wc);
    d = wd;
    c = wc;
    @(posedge clk);
    #1;
    m0 = model_step(m0, wd, wc, 1'b1);
    m1 = model_step(m1, wd, wc, 1'b0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    d = W_IDLE;
    c = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    m0 = m_init();
    m1 = m_init();
    resetn = 1'b1;
  endtask

  typedef struct {
    logic [63:0] d;
    logic [7:0]  c;
    logic [4:0]  ev;
    bit          ck;
    logic [47:0] da;
    logic [47:0] sa;
    logic [15:0] lt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(logic [63:0] wd, logic [7:0] wc, logic [4:0] ev);
    vec_t r;
    r.d = wd; r.c = wc; r.ev = ev; r.ck = 0; r.da = '0; r.sa = '0; r.lt = '0;
    return r;
  endfunction

  function automatic vec_t vk(logic [63:0] wd, logic [7:0] wc, logic [4:0] ev,
                              logic [47:0] da, logic [47:0] sa, logic [15:0] lt);
    vec_t r;
    r = v(wd, wc, ev);
    r.ck = 1; r.da = da; r.sa = sa; r.lt = lt;
    return r;
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    logic [63:0] wd;
    logic [7:0]  wc;
    int          r, k;

    // good frame, preamble error, second frame, short frame
    tbl.push_back(v(W_IDLE,  8'hFF, 5'b00000));
    tbl.push_back(v(W_START, 8'h01, 5'b00001));
    tbl.push_back(v(W_DA1,   8'h00, 5'b10001));
    tbl.push_back(vk(W_SALT, 8'h00, 5'b01001, 48'h0180C2000001, 48'h001122334455, 16'h8808));
    tbl.push_back(v(W_PAY,   8'h00, 5'b00001));
    tbl.push_back(v(W_TERM,  8'hFF, 5'b00000));
    tbl.push_back(v(W_BADPR, 8'h01, 5'b00101));
    tbl.push_back(v(W_DA1,   8'h00, 5'b00001));
    tbl.push_back(v(W_TERM,  8'hFF, 5'b00000));
    tbl.push_back(v(W_START, 8'h01, 5'b00001));
    tbl.push_back(v(W_DA2,   8'h00, 5'b10001));
    tbl.push_back(v(W_SALT,  8'h00, 5'b01001));
    tbl.push_back(v(W_TERM,  8'hFF, 5'b00000));
    tbl.push_back(v(W_START, 8'h01, 5'b00001));
    tbl.push_back(v(W_SHORT, 8'hFC, 5'b00010));
    tbl.push_back(vk(W_IDLE, 8'hFF, 5'b00000, 48'h112233445566, 48'hAABB22334455, 16'h8808));
    // missing Terminate: Start in PAYLOAD (silent), Start in SA_LT (hdr_err)
    tbl.push_back(v(W_START, 8'h01, 5'b00001));
    tbl.push_back(v(W_DA1,   8'h00, 5'b10001));
    tbl.push_back(v(W_SALT,  8'h00, 5'b01001));
    tbl.push_back(v(W_PAY,   8'h00, 5'b00001));
    tbl.push_back(v(W_START, 8'h01, 5'b00001));
    tbl.push_back(v(W_DA2,   8'h00, 5'b10001));
    tbl.push_back(v(W_START, 8'h01, 5'b00011));
    tbl.push_back(v(W_DA1,   8'h00, 5'b10001));
    tbl.push_back(vk(W_SALT, 8'h00, 5'b01001, 48'h0180C2000001, 48'h001122334455, 16'h8808));
    tbl.push_back(v(W_TERM,  8'hFF, 5'b00000));
    // Error character in the DA word -> hdr_err and drop until Terminate
    tbl.push_back(v(W_START, 8'h01, 5'b00001));
    tbl.push_back(v(W_ERR,   8'h01, 5'b00011));
    tbl.push_back(v(W_PAY,   8'h00, 5'b00001));
    tbl.push_back(v(W_TERM,  8'hFF, 5'b00000));

    resetn = 1'b0;
    d = W_IDLE;
    c = 8'hFF;
    m0 = m_init();
    m1 = m_init();
    do_reset();
    check("reset_state_a", pack_a(), '0);
    check("reset_state_b", pack_b(), '0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].d, tbl[i].c);
      check($sformatf("vec%0d_flags", i),
            {a_da_valid, a_hdr_valid, a_preamble_err, a_hdr_err, a_in_frame}, tbl[i].ev);
      if (tbl[i].ck) begin
        check($sformatf("vec%0d_addrs", i), {a_da_addr, a_sa_addr, a_len_type},
              {tbl[i].da, tbl[i].sa, tbl[i].lt});
      end
    end

    // synchronous reset while the SA/Length word is on the bus
    drive(W_START, 8'h01);
    drive(W_DA1, 8'h00);
    check("pre_reset_da_valid", {a_da_valid, a_da_addr}, {1'b1, 48'h0180C2000001});
    resetn = 1'b0;
    d = W_SALT;
    c = 8'h00;
    @(posedge clk);
    #1;
    m0 = m_init();
    m1 = m_init();
    check("reset_mid_sa_lt", pack_a(), '0);
    resetn = 1'b1;
    drive(W_PAY, 8'h00);
    check("after_reset_pay", pack_a(), '0);
    drive(W_SALT, 8'h00);
    check("after_reset_salt", pack_a(), '0);
    drive(W_TERM, 8'hFF);
    check("after_reset_term", pack_a(), '0);

    // SFD of 8'hD4: rejected with the check enabled, accepted without it
    drive(W_SFD4, 8'h01);
    check("sfd4_chk_flags", {a_da_valid, a_hdr_valid, a_preamble_err, a_hdr_err, a_in_frame}, 5'b00101);
    check("sfd4_nochk_flags", {b_da_valid, b_hdr_valid, b_preamble_err, b_hdr_err, b_in_frame}, 5'b00001);
    drive(W_DA1, 8'h00);
    check("sfd4_chk_da", {a_da_valid, a_in_frame}, 2'b01);
    check("sfd4_nochk_da", {b_da_valid, b_da_addr}, {1'b1, 48'h0180C2000001});
    drive(W_TERM, 8'hFF);

    // randomized traffic against the reference model, both parameterisations
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      r = $urandom_range(0, 99);
      wd = rand64();
      wc = 8'h00;
      if (r < 14) begin
        wd = W_START; wc = 8'h01;
      end else if (r < 18) begin
        k = $urandom_range(1, 7);
        wd = W_START ^ (64'h1 << (8 * k + $urandom_range(0, 7)));
        wc = 8'h01;
      end else if (r < 62) begin
        wc = 8'h00;
      end else if (r < 72) begin
        k = $urandom_range(0, 7);
        for (int i = 0; i < 8; i++) begin
          if (i == k) begin wd[8*i +: 8] = 8'hFD; wc[i] = 1'b1; end
          else if (i > k) begin wd[8*i +: 8] = 8'h07; wc[i] = 1'b1; end
        end
      end else if (r < 77) begin
        k = $urandom_range(0, 7);
        wd[8*k +: 8] = 8'hFE;
        wc[k] = 1'b1;
      end else if (r < 90) begin
        wd = W_IDLE; wc = 8'hFF;
      end else begin
        wc = 8'($urandom());
      end
      drive(wd, wc);
      check($sformatf("rand%0d_chk", n), pack_a(), pack_m(m0));
      check($sformatf("rand%0d_nochk", n), pack_b(), pack_m(m1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
